pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 16-bit, 5-stage core. Sits beside the decode stage and drives the enable, flush and bubble controls of the PC and the IF/ID, ID/EX and EX/MEM registers.
- Resolves load-use interlocks and EX-resolved control redirects.
- Freezes the pipe on data-memory wait.
- Keeps saturating stall and flush event counters for bring-up.

Parameters:
CNT_W, 16, width of each event counter
RA_W, 3, register-address width (8 GPRs)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a live instruction
id_ir  in  16  instruction in ID; 16'h0000 is NOP
ex_valid  in  1  ID/EX holds a live instruction
ex_ld  in  1  EX instruction is LW (opcode 0100)
ex_rd  in  RA_W  EX destination register
ex_redirect  in  1  EX resolved taken branch/jump (BEQ/BLT/BLE/JAL/JLR/JRI)
mem_busy  in  1  data memory not ready
cnt_clr  in  1  synchronous clear of both counters
pc_en  out  1  PC register load enable
pc_redir_sel  out  1  PC mux selects EX redirect target
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP (16'h0000)
idex_en  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX loads NOP
exmem_en  out  1  EX/MEM load enable
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  redirects performed, saturating

Behaviour:
Clock and reset:
- One clock domain; rst_n is asynchronous assert, synchronous deassert handled upstream.
- Reset values: state=RUN, both counters 0.
- Controls are combinational from state and inputs. While rst_n is low the outputs are forced to the RUN/idle values: all enables 1, flush/bubble/redir_sel 0.

Source-use decode by opcode id_ir[15:12]. Fields are RA=[11:9], RB=[8:6].
- 0000 uses RA.
- 0001, 0010, 0101, 1000, 1001, 1010 use RA and RB.
- 0100 and 1101 use RB.
- 1111 uses RA.
- 0011, 1100, all other opcodes, and id_ir==0 use none.

Hazard condition:
- lu_hz = id_valid & ex_valid & ex_ld & (src RA==ex_rd or src RB==ex_rd, counting only used fields).
- ALU results are forwarded elsewhere, so lu_hz is the only data interlock.

FSM states: RUN, REDIR_PEND.

Priority in RUN (first match wins):
1. mem_busy=1
   - pc_en, ifid_en, idex_en, exmem_en all 0.
   - If ex_redirect=1, next state is REDIR_PEND and nothing is flushed yet.
2. ex_redirect=1
   - pc_en=1, pc_redir_sel=1, ifid_flush=1, idex_bubble=1, other enables 1.
   - flush_cnt increments.
   - A simultaneous lu_hz is ignored because the ID instruction is killed.
3. lu_hz=1
   - pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1.
   - stall_cnt increments.
   - Exactly one stall cycle per load.
4. Otherwise all enables are 1 and all flush/bubble/redir_sel are 0.

REDIR_PEND:
- While mem_busy=1: all enables 0; stay in REDIR_PEND.
- On the first cycle with mem_busy=0: perform the redirect actions of case 2 (flush_cnt +1) whether or not ex_redirect is still high, then return to RUN.
- A redirect is never lost or performed twice.

Counters:
- cnt_clr has priority over increment.
- Each counter holds at all-ones (2^CNT_W-1) and never wraps.

Decomposition:
- Package pipe_pkg holds:
  - opcode localparams (OP_ADI=0000, OP_ADD=0001, OP_NAND=0010, OP_LLI=0011, OP_LW=0100, OP_SW=0101, OP_BEQ=1000, OP_BLT=1001, OP_BLE=1010, OP_JAL=1100, OP_JLR=1101, OP_JRI=1111);
  - the NOP constant 16'h0000;
  - the state encoding.
- One combinational sub-module, hz_src_dec: input id_ir; outputs use_ra, use_rb, ra, rb.
- FSM, priority logic and counters live in pipe_hazard_ctrl.

Test Plan:
- Reset: drive rst_n=0 mid-stream with ex_redirect=1 -> outputs idle, counters 0, state RUN; after release with no hazard all enables are 1.
- Load-use: ex_ld=1, ex_rd=3, id_ir=16'h1680 (ADD using RA=3) -> exactly one cycle of pc_en=0, ifid_en=0, idex_bubble=1; stall_cnt=1.
- No false hazard: ex_ld=1, ex_rd=3, id_ir=16'h3600 (LLI using RA=3) -> no stall. Same with id_ir=0 -> no stall.
- Redirect over load-use: ex_redirect=1 in the same cycle as lu_hz -> pc_redir_sel=1, ifid_flush=1, idex_bubble=1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
- Busy redirect: ex_redirect pulses for 1 cycle while mem_busy=1 for 3 cycles -> all enables 0 for those 3 cycles, then a single redirect cycle on the 4th; flush_cnt +1 exactly once.
- Saturation: preload by forcing 65535 stalls -> stall_cnt stays 16'hFFFF on the next stall; cnt_clr together with a stall -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared opcode, NOP and FSM state definitions for the pipeline hazard controller.
package pipe_pkg;

    localparam logic [3:0] OP_ADI  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LLI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BLT  = 4'b1001;
    localparam logic [3:0] OP_BLE  = 4'b1010;
    localparam logic [3:0] OP_JAL  = 4'b1100;
    localparam logic [3:0] OP_JLR  = 4'b1101;
    localparam logic [3:0] OP_JRI  = 4'b1111;

    localparam logic [15:0] NOP_IR = 16'h0000;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_REDIR_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hz_src_dec.sv
// Decodes which source register fields the ID-stage instruction actually reads.
module hz_src_dec
    import pipe_pkg::*;
#(
    parameter int RA_W = 3
) (
    input  logic [15:0]     id_ir_i,
    output logic            use_ra_o,
    output logic            use_rb_o,
    output logic [RA_W-1:0] ra_o,
    output logic [RA_W-1:0] rb_o
);

    logic [3:0] opcode;

    assign opcode = id_ir_i[15:12];
    assign ra_o   = id_ir_i[11 -: RA_W];
    assign rb_o   = id_ir_i[8 -: RA_W];

    // The all-zero word is a NOP even though it shares the ADI opcode.
    always_comb begin
        use_ra_o = 1'b0;
        use_rb_o = 1'b0;
        if (id_ir_i != NOP_IR) begin
            case (opcode)
                OP_ADI, OP_JRI: use_ra_o = 1'b1;
                OP_ADD, OP_NAND, OP_SW, OP_BEQ, OP_BLT, OP_BLE: begin
                    use_ra_o = 1'b1;
                    use_rb_o = 1'b1;
                end
                OP_LW, OP_JLR: use_rb_o = 1'b1;
                default: begin
                    use_ra_o = 1'b0;
                    use_rb_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use interlock, EX redirects, memory-wait freeze and event counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [15:0]      id_ir_i,
    input  logic             ex_valid_i,
    input  logic             ex_ld_i,
    input  logic [RA_W-1:0]  ex_rd_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    input  logic             cnt_clr_i,
    output logic             pc_en_o,
    output logic             pc_redir_sel_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_en_o,
    output logic             idex_bubble_o,
    output logic             exmem_en_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              use_ra, use_rb;
    logic [RA_W-1:0]   ra, rb;
    logic              lu_hz;
    logic              stall_inc, flush_inc;

    hz_src_dec #(.RA_W(RA_W)) u_src_dec (
        .id_ir_i  (id_ir_i),
        .use_ra_o (use_ra),
        .use_rb_o (use_rb),
        .ra_o     (ra),
        .rb_o     (rb)
    );

    assign lu_hz = id_valid_i & ex_valid_i & ex_ld_i &
                   ((use_ra & (ra == ex_rd_i)) | (use_rb & (rb == ex_rd_i)));

    // Outputs default to the free-running values and stay there while in reset.
    always_comb begin
        pc_en_o        = 1'b1;
        pc_redir_sel_o = 1'b0;
        ifid_en_o      = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_en_o      = 1'b1;
        idex_bubble_o  = 1'b0;
        exmem_en_o     = 1'b1;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        state_d        = state_q;
        if (!rst_n) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_busy_i) begin
                        pc_en_o    = 1'b0;
                        ifid_en_o  = 1'b0;
                        idex_en_o  = 1'b0;
                        exmem_en_o = 1'b0;
                        if (ex_redirect_i) state_d = ST_REDIR_PEND;
                    end else if (ex_redirect_i) begin
                        pc_redir_sel_o = 1'b1;
                        ifid_flush_o   = 1'b1;
                        idex_bubble_o  = 1'b1;
                        flush_inc      = 1'b1;
                    end else if (lu_hz) begin
                        pc_en_o       = 1'b0;
                        ifid_en_o     = 1'b0;
                        idex_bubble_o = 1'b1;
                        stall_inc     = 1'b1;
                    end
                end
                ST_REDIR_PEND: begin
                    if (mem_busy_i) begin
                        pc_en_o    = 1'b0;
                        ifid_en_o  = 1'b0;
                        idex_en_o  = 1'b0;
                        exmem_en_o = 1'b0;
                    end else begin
                        pc_redir_sel_o = 1'b1;
                        ifid_flush_o   = 1'b1;
                        idex_bubble_o  = 1'b1;
                        flush_inc      = 1'b1;
                        state_d        = ST_RUN;
                    end
                end
            endcase
        end
    end

    // Clear wins over increment; counters stick at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MAXC = 65535;

    localparam logic [6:0] V_IDLE  = 7'b1010101;
    localparam logic [6:0] V_FROZE = 7'b0000000;
    localparam logic [6:0] V_REDIR = 7'b1111111;
    localparam logic [6:0] V_STALL = 7'b0000111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [15:0] id_ir = 16'h0000;
    logic        ex_valid = 1'b0;
    logic        ex_ld = 1'b0;
    logic [2:0]  ex_rd = 3'd0;
    logic        ex_redirect = 1'b0;
    logic        mem_busy = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        pc_en, pc_redir_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;
    logic [15:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad = 0;
    bit mPend = 0;
    int mStall = 0;
    int mFlush = 0;

    pipe_hazard_ctrl #(.CNT_W(16), .RA_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_ir_i        (id_ir),
        .ex_valid_i     (ex_valid),
        .ex_ld_i        (ex_ld),
        .ex_rd_i        (ex_rd),
        .ex_redirect_i  (ex_redirect),
        .mem_busy_i     (mem_busy),
        .cnt_clr_i      (cnt_clr),
        .pc_en_o        (pc_en),
        .pc_redir_sel_o (pc_redir_sel),
        .ifid_en_o      (ifid_en),
        .ifid_flush_o   (ifid_flush),
        .idex_en_o      (idex_en),
        .idex_bubble_o  (idex_bubble),
        .exmem_en_o     (exmem_en),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Does the instruction read register r through a field it actually uses?
    function automatic bit readsReg(input logic [15:0] ir, input logic [2:0] r);
        logic [3:0] op;
        bit usesA, usesB;
        op = ir[15:12];
        usesA = (op inside {4'h0, 4'h1, 4'h2, 4'h5, 4'h8, 4'h9, 4'hA, 4'hF});
        usesB = (op inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hD});
        if (ir == 16'h0000) return 1'b0;
        return (usesA && ir[11:9] == r) || (usesB && ir[8:6] == r);
    endfunction

    function automatic int satInc(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic applyStimulus(input bit idv, input logic [15:0] ir, input bit exv, input bit ld,
                                 input logic [2:0] rd, input bit redir, input bit busy, input bit clr);
        logic [6:0] expV;
        bit hz, doStall, doFlush, nextPend;
        @(negedge clk);
        id_valid = idv; id_ir = ir; ex_valid = exv; ex_ld = ld; ex_rd = rd;
        ex_redirect = redir; mem_busy = busy; cnt_clr = clr;
        #1;
        hz = idv && exv && ld && readsReg(ir, rd);
        doStall = 0; doFlush = 0; nextPend = mPend;
        if (busy) begin
            expV = V_FROZE;
            if (!mPend && redir) nextPend = 1;
        end else if (mPend || redir) begin
            expV = V_REDIR; doFlush = 1; nextPend = 0;
        end else if (hz) begin
            expV = V_STALL; doStall = 1;
        end else begin
            expV = V_IDLE;
        end
        checkOutput("ctrl", {25'd0, pc_en, pc_redir_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en},
                    {25'd0, expV});
        @(posedge clk);
        #1;
        mPend = nextPend;
        if (clr) begin
            mStall = 0; mFlush = 0;
        end else begin
            if (doStall) mStall = satInc(mStall);
            if (doFlush) mFlush = satInc(mFlush);
        end
        checkOutput("stall_cnt", {16'd0, stall_cnt}, mStall);
        checkOutput("flush_cnt", {16'd0, flush_cnt}, mFlush);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; ex_redirect = 1'b1; mem_busy = 1'b1; id_valid = 1'b1; id_ir = 16'h1680;
        ex_valid = 1'b1; ex_ld = 1'b1; ex_rd = 3'd3;
        #1;
        mPend = 0; mStall = 0; mFlush = 0;
        checkOutput("rst_ctrl", {25'd0, pc_en, pc_redir_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en},
                    {25'd0, V_IDLE});
        checkOutput("rst_stall", {16'd0, stall_cnt}, 0);
        checkOutput("rst_flush", {16'd0, flush_cnt}, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold", {25'd0, pc_en, pc_redir_sel, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en},
                    {25'd0, V_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        ex_redirect = 1'b0; mem_busy = 1'b0; id_valid = 1'b0; ex_valid = 1'b0; ex_ld = 1'b0;
    endtask

    initial begin
        int s0, f0;
        doReset();
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0);

        // Load-use then the load has moved on.
        s0 = mStall;
        applyStimulus(1, 16'h1680, 1, 1, 3'd3, 0, 0, 0);
        applyStimulus(1, 16'h1680, 0, 0, 3'd3, 0, 0, 0);
        checkOutput("lu_one_stall", stall_cnt - s0, 1);

        // Fields that are not read must not interlock.
        applyStimulus(1, 16'h3600, 1, 1, 3'd3, 0, 0, 0);
        applyStimulus(1, 16'h0000, 1, 1, 3'd0, 0, 0, 0);

        // Redirect kills the hazarding instruction.
        s0 = mStall; f0 = mFlush;
        applyStimulus(1, 16'h1680, 1, 1, 3'd3, 1, 0, 0);
        checkOutput("redir_flush", flush_cnt - f0, 1);
        checkOutput("redir_nostall", stall_cnt - s0, 0);

        // Redirect arriving under a 3-cycle memory wait.
        f0 = mFlush;
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 1, 1, 0);
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 0, 1, 0);
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 0, 1, 0);
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0);
        checkOutput("busy_redir_once", flush_cnt - f0, 1);

        // Mid-stream reset with a redirect pending.
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 1, 1, 0);
        doReset();
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ir;
            ir = 16'($urandom);
            ir[11:9] = 3'($urandom_range(0, 3));
            ir[8:6]  = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) ir = 16'h0000;
            applyStimulus($urandom_range(0, 3) != 0, ir, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1, 3'($urandom_range(0, 3)),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 49) == 0);
        end

        // Saturation: drive the stall counter to all-ones.
        applyStimulus(0, 16'h0000, 0, 0, 3'd0, 0, 0, 1);
        for (int i = 0; i < MAXC; i++) applyStimulus(1, 16'h1680, 1, 1, 3'd3, 0, 0, 0);
        checkOutput("sat_reach", {16'd0, stall_cnt}, 32'h0000FFFF);
        applyStimulus(1, 16'h1680, 1, 1, 3'd3, 0, 0, 0);
        checkOutput("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
        applyStimulus(1, 16'h1680, 1, 1, 3'd3, 0, 0, 1);
        checkOutput("clr_over_inc", {16'd0, stall_cnt}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
